// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply engine.
package matmul_pkg;

  localparam int unsigned DIM    = 3;
  localparam int unsigned NELEM  = DIM * DIM;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ELEM_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FINISH
  } state_t;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [ELEM_W-1:0] elem_t;

  // Row-major flat index of element (row, col).
  function automatic elem_t flat_idx(input idx_t row, input idx_t col);
    return ELEM_W'(row) * ELEM_W'(DIM) + ELEM_W'(col);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate: sum = (clr ? 0 : acc_in) + a*b, wrapping at ACC_W.
module matmul_mac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic                     clr,
  output logic signed [ACC_W-1:0]  sum
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  base;

  // Full-width signed product, sign-extended into the accumulator width.
  always_comb begin
    prod = PROD_W'(a) * PROD_W'(b);
    base = clr ? '0 : acc_in;
    sum  = base + ACC_W'(prod);
  end

endmodule

// File: rtl/matmul_controller.sv
// 3x3 signed matrix multiply C = A x B over parameter-defined operands,
// one MAC per clock, results exposed as nine registered outputs.
module matmul_controller
  import matmul_pkg::*;
#(
  parameter int unsigned          DATA_W = 16,
  parameter int unsigned          ACC_W  = 32,
  parameter logic [9*DATA_W-1:0]  A_INIT = {DATA_W'(9), DATA_W'(8), DATA_W'(7),
                                            DATA_W'(6), DATA_W'(5), DATA_W'(4),
                                            DATA_W'(3), DATA_W'(2), DATA_W'(1)},
  parameter logic [9*DATA_W-1:0]  B_INIT = {DATA_W'(1), DATA_W'(2), DATA_W'(3),
                                            DATA_W'(4), DATA_W'(5), DATA_W'(6),
                                            DATA_W'(7), DATA_W'(8), DATA_W'(9)}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    START_CONTROLLER,
  output logic                    DONE,
  output logic signed [ACC_W-1:0] Result_0,
  output logic signed [ACC_W-1:0] Result_1,
  output logic signed [ACC_W-1:0] Result_2,
  output logic signed [ACC_W-1:0] Result_3,
  output logic signed [ACC_W-1:0] Result_4,
  output logic signed [ACC_W-1:0] Result_5,
  output logic signed [ACC_W-1:0] Result_6,
  output logic signed [ACC_W-1:0] Result_7,
  output logic signed [ACC_W-1:0] Result_8
);

  localparam idx_t LAST = IDX_W'(DIM - 1);

  state_t                   state;
  idx_t                     i, j, k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  result [NELEM];
  logic                     done_q;

  logic signed [DATA_W-1:0] a_rom [NELEM];
  logic signed [DATA_W-1:0] b_rom [NELEM];
  logic signed [DATA_W-1:0] a_op, b_op;
  logic signed [ACC_W-1:0]  sum;

  // Operand ROMs: element 0 sits in the least-significant slice.
  always_comb begin
    for (int unsigned n = 0; n < NELEM; n++) begin
      a_rom[n] = A_INIT[n*DATA_W +: DATA_W];
      b_rom[n] = B_INIT[n*DATA_W +: DATA_W];
    end
    a_op = a_rom[flat_idx(i, k)];
    b_op = b_rom[flat_idx(k, j)];
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a      (a_op),
    .b      (b_op),
    .acc_in (acc),
    .clr    (k == '0),
    .sum    (sum)
  );

  // Control FSM, loop counters, accumulator and result register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      acc    <= '0;
      done_q <= 1'b0;
      for (int unsigned n = 0; n < NELEM; n++) result[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START_CONTROLLER) begin
            state <= COMPUTE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            for (int unsigned n = 0; n < NELEM; n++) result[n] <= '0;
          end
        end
        COMPUTE: begin
          if (k != LAST) begin
            acc <= sum;
            k   <= k + 1'b1;
          end else begin
            result[flat_idx(i, j)] <= sum;
            acc <= '0;
            k   <= '0;
            if (j != LAST) begin
              j <= j + 1'b1;
            end else begin
              j <= '0;
              if (i != LAST) begin
                i <= i + 1'b1;
              end else begin
                i      <= '0;
                state  <= FINISH;
                done_q <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          // Hold results until start is released; no automatic restart.
          if (!START_CONTROLLER) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign DONE     = done_q;
  assign Result_0 = result[0];
  assign Result_1 = result[1];
  assign Result_2 = result[2];
  assign Result_3 = result[3];
  assign Result_4 = result[4];
  assign Result_5 = result[5];
  assign Result_6 = result[6];
  assign Result_7 = result[7];
  assign Result_8 = result[8];

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller: three operand sets run in lockstep against a
// plain-arithmetic matrix-product model, with randomized start/abort timing.
module tb_matmul_controller;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned ND = 3;

  localparam logic [9*DW-1:0] AP [ND] = '{
    {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
    {16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF},
    {9{16'h7FFF}}
  };
  localparam logic [9*DW-1:0] BP [ND] = '{
    {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9},
    {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9},
    {9{16'h7FFF}}
  };
  localparam int SPEC_C [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 done_w [ND];
  logic signed [AW-1:0] res    [ND][9];
  logic signed [AW-1:0] expv   [ND][9];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    matmul_controller #(
      .DATA_W (DW),
      .ACC_W  (AW),
      .A_INIT (AP[g]),
      .B_INIT (BP[g])
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .START_CONTROLLER (start),
      .DONE             (done_w[g]),
      .Result_0         (res[g][0]),
      .Result_1         (res[g][1]),
      .Result_2         (res[g][2]),
      .Result_3         (res[g][3]),
      .Result_4         (res[g][4]),
      .Result_5         (res[g][5]),
      .Result_6         (res[g][6]),
      .Result_7         (res[g][7]),
      .Result_8         (res[g][8])
    );
  end

  // Reference: textbook triple loop in 64-bit, then reduced modulo 2^32.
  function automatic void model(input logic [9*DW-1:0] ap, input logic [9*DW-1:0] bp,
                                output logic signed [AW-1:0] c [9]);
    longint s;
    logic [DW-1:0] ae, be;
    for (int r = 0; r < 3; r++) begin
      for (int col = 0; col < 3; col++) begin
        s = 0;
        for (int t = 0; t < 3; t++) begin
          ae = ap[(3*r+t)*DW +: DW];
          be = bp[(3*t+col)*DW +: DW];
          s += longint'($signed(ae)) * longint'($signed(be));
        end
        c[3*r+col] = s[31:0];
      end
    end
  endfunction

  // Drives one run from IDLE; checks DONE and progressive results after every edge.
  // drop_at: edge after which start is released; abort_at: edge after which reset hits.
  task automatic do_run(input string name, input int drop_at, input int abort_at);
    logic signed [AW-1:0] ev;
    logic                 exp_done;
    start = 1'b1;
    for (int m = 1; m <= 28; m++) begin
      @(posedge clk);
      @(negedge clk);
      exp_done = (m >= 28);
      for (int g = 0; g < ND; g++) begin
        total++;
        if (done_w[g] !== exp_done) begin
          bad++;
          $display("FAIL %s done dut%0d edge%0d got %b exp %b", name, g, m, done_w[g], exp_done);
        end
        for (int n = 0; n < 9; n++) begin
          ev = (m >= 3*n + 4) ? expv[g][n] : '0;
          total++;
          if (res[g][n] !== ev) begin
            bad++;
            $display("FAIL %s result dut%0d r%0d edge%0d got %0d exp %0d", name, g, n, m, res[g][n], ev);
          end
        end
      end
      if (m == drop_at) start = 1'b0;
      if (m == abort_at) begin
        #1 rst = 1'b0;
        #1;
        for (int g = 0; g < ND; g++) begin
          total++;
          if (done_w[g] !== 1'b0) begin
            bad++;
            $display("FAIL %s abort_done dut%0d got %b exp 0", name, g, done_w[g]);
          end
          for (int n = 0; n < 9; n++) begin
            total++;
            if (res[g][n] !== '0) begin
              bad++;
              $display("FAIL %s abort_result dut%0d r%0d got %0d exp 0", name, g, n, res[g][n]);
            end
          end
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    #2;
    for (int g = 0; g < ND; g++) begin
      total++;
      if (done_w[g] !== 1'b0) begin
        bad++;
        $display("FAIL reset_done dut%0d got %b exp 0", g, done_w[g]);
      end
      for (int n = 0; n < 9; n++) begin
        total++;
        if (res[g][n] !== '0) begin
          bad++;
          $display("FAIL reset_result dut%0d r%0d got %0d exp 0", g, n, res[g][n]);
        end
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (done_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL idle_done got %b exp 0", done_w[0]);
    end
  endtask

  task automatic test_defaults();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    do_run("defaults", 0, 0);
    // Held start: FINISH persists with stable outputs.
    repeat ($urandom_range(2, 6)) begin
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
        total++;
        if (done_w[g] !== 1'b1) begin
          bad++;
          $display("FAIL hold_done dut%0d got %b exp 1", g, done_w[g]);
        end
        for (int n = 0; n < 9; n++) begin
          total++;
          if (res[g][n] !== expv[g][n]) begin
            bad++;
            $display("FAIL hold_result dut%0d r%0d got %0d exp %0d", g, n, res[g][n], expv[g][n]);
          end
        end
      end
    end
    for (int n = 0; n < 9; n++) begin
      total++;
      if (res[0][n] !== 32'(SPEC_C[n])) begin
        bad++;
        $display("FAIL spec_table r%0d got %0d exp %0d", n, res[0][n], SPEC_C[n]);
      end
    end
  endtask

  task automatic test_restart();
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < ND; g++) begin
      total++;
      if (done_w[g] !== 1'b0) begin
        bad++;
        $display("FAIL restart_exit_done dut%0d got %b exp 0", g, done_w[g]);
      end
      total++;
      if (res[g][4] !== expv[g][4]) begin
        bad++;
        $display("FAIL restart_idle_hold dut%0d got %0d exp %0d", g, res[g][4], expv[g][4]);
      end
    end
    do_run("restart", 0, 0);
  endtask

  task automatic test_start_drop();
    int drop;
    start = 1'b0;
    @(negedge clk);
    drop = int'($urandom_range(2, 27));
    do_run("start_drop", drop, 0);
    @(negedge clk);
    total++;
    if (done_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL drop_exit_done got %b exp 0", done_w[0]);
    end
  endtask

  task automatic test_pulse();
    repeat (2) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      do_run("pulse", 1, 0);
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
        total++;
        if (done_w[g] !== 1'b0) begin
          bad++;
          $display("FAIL pulse_exit_done dut%0d got %b exp 0", g, done_w[g]);
        end
        for (int n = 0; n < 9; n++) begin
          total++;
          if (res[g][n] !== expv[g][n]) begin
            bad++;
            $display("FAIL pulse_keep dut%0d r%0d got %0d exp %0d", g, n, res[g][n], expv[g][n]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int it = 0; it < 2; it++) begin
      start = 1'b0;
      @(negedge clk);
      do_run("reset_mid", 0, (it == 0) ? 11 : int'($urandom_range(2, 27)));
      @(negedge clk);
      total++;
      if (res[0][0] !== '0) begin
        bad++;
        $display("FAIL reset_held got %0d exp 0", res[0][0]);
      end
      rst = 1'b1;
      do_run("after_reset", 0, 0);
    end
  endtask

  initial begin
    for (int g = 0; g < ND; g++) begin
      logic signed [AW-1:0] tmp [9];
      model(AP[g], BP[g], tmp);
      for (int n = 0; n < 9; n++) expv[g][n] = tmp[n];
    end
    test_reset();
    test_defaults();
    test_restart();
    test_start_drop();
    test_pulse();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
